// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl
// Top-level game sequencer for the snake game. Owns the game status that
// drives the movement datapath, wall display and apple logic; turns
// collision flags into a timed death flash; times the reward-protection
// window; keeps the per-game score and the win flag.
//
// Ports
//   i_clk               system clock
//   i_rst               synchronous, active-high reset
//   i_start_press       debounced key pulse (any direction key)
//   i_hit_wall          wall collision level from the movement block
//   i_hit_body          body collision level from the movement block
//   i_add_cube          high while the head sits on the apple
//   i_reward_hit        one-cycle pulse when a reward item is eaten
//   i_cube_num[6:0]     current body length
//   o_game_status[1:0]  00 RESTART, 01 START, 10 PLAY, 11 DIE
//   o_die_flash         1 = snake visible, 0 = snake blanked
//   o_reward_protected  1 = datapath ignores collisions
//   o_score[7:0]        apples eaten this game, saturating at 255
//   o_win               game ended because the snake reached MAX_LEN
module snake_game_ctrl #(
    parameter int FLASH_HALF     = 12_500_000,
    parameter int FLASH_TOGGLES  = 8,
    parameter int PROTECT_CYCLES = 250_000_000,
    parameter int RESTART_CYCLES = 2,
    parameter int MAX_LEN        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_press,
    input  logic       i_hit_wall,
    input  logic       i_hit_body,
    input  logic       i_add_cube,
    input  logic       i_reward_hit,
    input  logic [6:0] i_cube_num,
    output logic [1:0] o_game_status,
    output logic       o_die_flash,
    output logic       o_reward_protected,
    output logic [7:0] o_score,
    output logic       o_win
);

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } state_t;

    // Each counter only ever holds 0 .. terminal, so $clog2 of the
    // parameter is enough; the max() guards keep a 1-bit minimum.
    localparam int HALF_W = (FLASH_HALF > 1)     ? $clog2(FLASH_HALF)     : 1;
    localparam int TOG_W  = (FLASH_TOGGLES > 1)  ? $clog2(FLASH_TOGGLES)  : 1;
    localparam int PROT_W = (PROTECT_CYCLES > 1) ? $clog2(PROTECT_CYCLES) : 1;
    localparam int RST_W  = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(FLASH_HALF - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(FLASH_TOGGLES - 1);
    localparam logic [PROT_W-1:0] PROT_LOAD = PROT_W'(PROTECT_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RESTART_CYCLES - 1);
    localparam logic [6:0]        WIN_LEN   = 7'(MAX_LEN);

    state_t              r_state,    w_state_nxt;
    logic [HALF_W-1:0]   r_half_cnt, w_half_cnt_nxt;
    logic [TOG_W-1:0]    r_tog_cnt,  w_tog_cnt_nxt;
    logic [PROT_W-1:0]   r_prot_cnt, w_prot_cnt_nxt;
    logic [RST_W-1:0]    r_rst_cnt,  w_rst_cnt_nxt;
    logic                r_flash,    w_flash_nxt;
    logic                r_prot,     w_prot_nxt;
    logic [7:0]          r_score,    w_score_nxt;
    logic                r_win,      w_win_nxt;
    logic                r_add_cube_d;

    logic                w_collision;
    logic                w_add_rise;

    assign w_collision = i_hit_wall | i_hit_body;
    assign w_add_rise  = i_add_cube & ~r_add_cube_d;

    // Next-state and next-value logic for every registered output and counter.
    always_comb begin
        w_state_nxt    = r_state;
        w_half_cnt_nxt = r_half_cnt;
        w_tog_cnt_nxt  = r_tog_cnt;
        w_prot_cnt_nxt = r_prot_cnt;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_flash_nxt    = r_flash;
        w_prot_nxt     = r_prot;
        w_score_nxt    = r_score;
        w_win_nxt      = r_win;

        case (r_state)
            ST_RESTART: begin
                w_flash_nxt = 1'b1;
                if (r_rst_cnt == RST_LAST) begin
                    w_rst_cnt_nxt = {RST_W{1'b0}};
                    w_state_nxt   = ST_START;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                end
            end

            ST_START: begin
                if (i_start_press) begin
                    w_state_nxt = ST_PLAY;
                    w_score_nxt = 8'd0;
                    w_win_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end

            ST_PLAY: begin
                if (w_collision || (i_cube_num >= WIN_LEN)) begin
                    // Collision outranks the win; either way the flash
                    // sequence and the protection window start from zero.
                    w_state_nxt    = ST_DIE;
                    w_win_nxt      = ~w_collision;
                    w_prot_nxt     = 1'b0;
                    w_prot_cnt_nxt = {PROT_W{1'b0}};
                    w_half_cnt_nxt = {HALF_W{1'b0}};
                    w_tog_cnt_nxt  = {TOG_W{1'b0}};
                    w_flash_nxt    = 1'b1;
                end else begin
                    if (i_reward_hit) begin
                        // A fresh hit reloads rather than adds: no stacking.
                        w_prot_nxt     = 1'b1;
                        w_prot_cnt_nxt = PROT_LOAD;
                    end else if (r_prot) begin
                        if (r_prot_cnt == {PROT_W{1'b0}}) begin
                            w_prot_nxt = 1'b0;
                        end else begin
                            w_prot_cnt_nxt = r_prot_cnt - 1'b1;
                        end
                    end else begin
                        w_prot_nxt = 1'b0;
                    end
                end

                // A coincident collision suppresses the increment.
                if (!w_collision && w_add_rise && (r_score != 8'hFF)) begin
                    w_score_nxt = r_score + 8'd1;
                end else begin
                    w_score_nxt = w_score_nxt;
                end
            end

            ST_DIE: begin
                if (r_half_cnt == HALF_LAST) begin
                    w_half_cnt_nxt = {HALF_W{1'b0}};
                    if (r_tog_cnt == TOG_LAST) begin
                        // Last toggle: leave visible and restart on this edge.
                        w_tog_cnt_nxt = {TOG_W{1'b0}};
                        w_flash_nxt   = 1'b1;
                        w_state_nxt   = ST_RESTART;
                    end else begin
                        w_tog_cnt_nxt = r_tog_cnt + 1'b1;
                        w_flash_nxt   = ~r_flash;
                    end
                end else begin
                    w_half_cnt_nxt = r_half_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_RESTART;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RESTART;
            r_half_cnt   <= {HALF_W{1'b0}};
            r_tog_cnt    <= {TOG_W{1'b0}};
            r_prot_cnt   <= {PROT_W{1'b0}};
            r_rst_cnt    <= {RST_W{1'b0}};
            r_flash      <= 1'b1;
            r_prot       <= 1'b0;
            r_score      <= 8'd0;
            r_win        <= 1'b0;
            r_add_cube_d <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_half_cnt   <= w_half_cnt_nxt;
            r_tog_cnt    <= w_tog_cnt_nxt;
            r_prot_cnt   <= w_prot_cnt_nxt;
            r_rst_cnt    <= w_rst_cnt_nxt;
            r_flash      <= w_flash_nxt;
            r_prot       <= w_prot_nxt;
            r_score      <= w_score_nxt;
            r_win        <= w_win_nxt;
            r_add_cube_d <= i_add_cube;
        end
    end

    assign o_game_status      = r_state;
    assign o_die_flash        = r_flash;
    assign o_reward_protected = r_prot;
    assign o_score            = r_score;
    assign o_win              = r_win;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Testbench for snake_game_ctrl. Stimulus runs on the falling edge and
// pushes the expected output vector, tagged with the cycle on which it must
// appear, into a scoreboard queue; a separate monitor pops and compares.
module tb_snake_game_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic       fl;
        logic       pr;
        logic [7:0] sc;
        logic       wn;
    } obs_t;

    localparam logic [1:0] S_RST  = 2'b00;
    localparam logic [1:0] S_STRT = 2'b01;
    localparam logic [1:0] S_PLAY = 2'b10;
    localparam logic [1:0] S_DIE  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_press = 1'b0;
    logic       hit_wall = 1'b0;
    logic       hit_body = 1'b0;
    logic       add_cube = 1'b0;
    logic       reward_hit = 1'b0;
    logic [6:0] cube_num = 7'd3;
    logic [1:0] game_status;
    logic       die_flash;
    logic       reward_protected;
    logic [7:0] score;
    logic       win;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    done = 1'b0;
    bit    mon_done = 1'b0;
    int    q_cyc[$];
    obs_t  q_exp[$];
    string q_name[$];

    snake_game_ctrl #(
        .FLASH_HALF    (4),
        .FLASH_TOGGLES (4),
        .PROTECT_CYCLES(10),
        .RESTART_CYCLES(2),
        .MAX_LEN       (6)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start_press     (start_press),
        .i_hit_wall        (hit_wall),
        .i_hit_body        (hit_body),
        .i_add_cube        (add_cube),
        .i_reward_hit      (reward_hit),
        .i_cube_num        (cube_num),
        .o_game_status     (game_status),
        .o_die_flash       (die_flash),
        .o_reward_protected(reward_protected),
        .o_score           (score),
        .o_win             (win)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect the given outputs k rising edges from now.
    task automatic exp_at(input int k, input logic [1:0] st, input logic fl,
                          input logic pr, input logic [7:0] sc, input logic wn,
                          input string nm);
        obs_t e;
        e.st = st; e.fl = fl; e.pr = pr; e.sc = sc; e.wn = wn;
        q_cyc.push_back(cyc + k);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    // Reset pulse, then the RESTART -> START sequence and idle in START.
    task automatic do_reset();
        rst = 1'b1;
        exp_at(1, S_RST, 1'b1, 1'b0, 8'd0, 1'b0, "reset_values");
        step(1);
        rst = 1'b0;
        exp_at(1, S_RST, 1'b1, 1'b0, 8'd0, 1'b0, "restart_hold");
        for (int k = 2; k <= 5; k++)
            exp_at(k, S_STRT, 1'b1, 1'b0, 8'd0, 1'b0, "start_idle");
        step(5);
    endtask

    task automatic press_start();
        start_press = 1'b1;
        exp_at(1, S_PLAY, 1'b1, 1'b0, 8'd0, 1'b0, "start_to_play");
        step(1);
        start_press = 1'b0;
    endtask

    // One add_cube pulse held 3 cycles; exactly one increment expected.
    task automatic add_pulse(input logic [7:0] s);
        add_cube = 1'b1;
        exp_at(1, S_PLAY, 1'b1, 1'b0, s, 1'b0, "score_step");
        exp_at(3, S_PLAY, 1'b1, 1'b0, s, 1'b0, "score_hold");
        step(3);
        add_cube = 1'b0;
        step(2);
    endtask

    // Monitor: compares every expectation whose cycle has arrived.
    initial begin
        obs_t  e;
        obs_t  g;
        string nm;
        int    c;
        forever begin
            @(negedge clk);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                c  = q_cyc.pop_front();
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                g.st = game_status; g.fl = die_flash; g.pr = reward_protected;
                g.sc = score; g.wn = win;
                checks++;
                if (g !== e || c != cyc) begin
                    errors++;
                    $display("FAIL %s @cyc %0d (due %0d): got st=%b fl=%b pr=%b sc=%0d win=%b, expected st=%b fl=%b pr=%b sc=%0d win=%b",
                             nm, cyc, c, g.st, g.fl, g.pr, g.sc, g.wn,
                             e.st, e.fl, e.pr, e.sc, e.wn);
                end
            end
            if (done && !mon_done) begin
                checks++;
                if (q_cyc.size() != 0) begin
                    errors++;
                    $display("FAIL queue_drain: %0d expectations left, expected 0", q_cyc.size());
                end
                mon_done = 1'b1;
            end
        end
    end

    initial begin
        step(1);
        do_reset();

        // reward_hit outside PLAY does nothing
        reward_hit = 1'b1;
        exp_at(1, S_STRT, 1'b1, 1'b0, 8'd0, 1'b0, "reward_ignored_start");
        step(1);
        reward_hit = 1'b0;
        step(1);

        // game 1: three apples then a wall
        press_start();
        add_pulse(8'd1);
        add_pulse(8'd2);
        add_pulse(8'd3);
        hit_wall = 1'b1;
        for (int k = 1; k <= 16; k++)
            exp_at(k, S_DIE, (((k - 1) / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 8'd3, 1'b0, "die_flash");
        exp_at(17, S_RST, 1'b1, 1'b0, 8'd3, 1'b0, "die_to_restart");
        exp_at(19, S_STRT, 1'b1, 1'b0, 8'd3, 1'b0, "score_held_start");
        step(1);
        hit_wall = 1'b0;
        step(4);
        start_press = 1'b1;       // ignored in DIE
        step(1);
        start_press = 1'b0;
        step(13);

        // game 2: reward window extended by a second hit
        press_start();
        reward_hit = 1'b1;
        for (int k = 1; k <= 17; k++)
            exp_at(k, S_PLAY, 1'b1, (k <= 15) ? 1'b1 : 1'b0, 8'd0, 1'b0, "protect_window");
        step(1);
        reward_hit = 1'b0;
        step(4);
        reward_hit = 1'b1;
        step(1);
        reward_hit = 1'b0;
        step(11);
        reward_hit = 1'b1;
        exp_at(1, S_PLAY, 1'b1, 1'b1, 8'd0, 1'b0, "protect_again");
        step(1);
        reward_hit = 1'b0;
        step(2);
        hit_body = 1'b1;
        exp_at(1, S_DIE, 1'b1, 1'b0, 8'd0, 1'b0, "hit_clears_protect");
        step(1);
        hit_body = 1'b0;
        step(3);
        do_reset();               // mid-DIE

        // game 3: reset mid-PLAY while protected with nonzero score
        press_start();
        reward_hit = 1'b1;
        exp_at(1, S_PLAY, 1'b1, 1'b1, 8'd0, 1'b0, "protect_before_rst");
        step(1);
        reward_hit = 1'b0;
        add_cube = 1'b1;
        exp_at(1, S_PLAY, 1'b1, 1'b1, 8'd1, 1'b0, "score_before_rst");
        step(1);
        add_cube = 1'b0;
        step(1);
        do_reset();

        // game 4: win by length
        press_start();
        add_pulse(8'd1);
        cube_num = 7'd6;
        exp_at(1, S_DIE, 1'b1, 1'b0, 8'd1, 1'b1, "win_die");
        exp_at(17, S_RST, 1'b1, 1'b0, 8'd1, 1'b1, "win_hold_restart");
        exp_at(19, S_STRT, 1'b1, 1'b0, 8'd1, 1'b1, "win_hold_start");
        step(1);
        cube_num = 7'd3;
        step(18);
        press_start();            // clears score and win

        // game 5: collision beats win
        hit_body = 1'b1;
        cube_num = 7'd6;
        exp_at(1, S_DIE, 1'b1, 1'b0, 8'd0, 1'b0, "collision_beats_win");
        step(1);
        hit_body = 1'b0;
        cube_num = 7'd3;
        step(18);

        // game 6: collision beats score increment
        press_start();
        add_pulse(8'd1);
        hit_wall = 1'b1;
        add_cube = 1'b1;
        exp_at(1, S_DIE, 1'b1, 1'b0, 8'd1, 1'b0, "collision_beats_score");
        step(1);
        hit_wall = 1'b0;
        add_cube = 1'b0;
        step(2);

        done = 1'b1;
        for (int i = 0; i < 50 && !mon_done; i++) step(1);
        if (!mon_done) $display("FAIL monitor_timeout: monitor did not finish, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + (mon_done ? 0 : 1));
        $finish;
    end

endmodule
